// File: rtl/aud_pkg.sv
// Shared types and helpers for the audio mixing scheduler and its saturator.
// Used by aud_mix_sched, including its optional AUD_MIX_ATTEN_EN attenuation build.
package aud_pkg;

    localparam int unsigned SampleWDefault = 16;

    typedef struct packed {
        logic signed [SampleWDefault-1:0] left;
        logic signed [SampleWDefault-1:0] right;
    } aud_frame_t;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StWait,
        StSat,
        StDone
    } mix_state_e;

    // Headroom for summing num_ch full-scale samples without wrap.
    function automatic int unsigned acc_width(input int unsigned num_ch,
                                              input int unsigned sample_w);
        return sample_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/aud_sat.sv
// Combinational saturating narrow of a signed accumulator to OutW bits.
module aud_sat #(
    parameter int unsigned InW  = 18,
    parameter int unsigned OutW = 16
) (
    input  logic [InW-1:0]  acc_i,
    output logic [OutW-1:0] sat_o
);

    if (InW > OutW) begin : g_narrow
        logic [InW-OutW:0] upper;

        always_comb begin
            upper = acc_i[InW-1:OutW-1];
            // In range only when all dropped bits match the new sign bit.
            if ((&upper) || !(|upper)) begin
                sat_o = acc_i[OutW-1:0];
            end else if (acc_i[InW-1]) begin
                sat_o = {1'b1, {(OutW-1){1'b0}}};
            end else begin
                sat_o = {1'b0, {(OutW-1){1'b1}}};
            end
        end
    end else begin : g_pass
        assign sat_o = acc_i;
    end

endmodule

// File: rtl/aud_mix_sched.sv
// Sequential fetch-and-accumulate mixer feeding i2s_tx; each request publishes the previous mix.
// Define AUD_MIX_ATTEN_EN to add per-source 4-bit arithmetic attenuation (ch_atten_i).
module aud_mix_sched
    import aud_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned SAMPLE_W = SampleWDefault,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    output logic [2*SAMPLE_W-1:0]        sample_o,
    input  logic [NUM_CH-1:0]            ch_en_i,
`ifdef AUD_MIX_ATTEN_EN
    input  logic [NUM_CH*4-1:0]          ch_atten_i,
`endif
    output logic [NUM_CH-1:0]            ch_req_o,
    input  logic [NUM_CH-1:0]            ch_valid_i,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_left_i,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_right_i,
    output logic                         busy_o,
    output logic                         underrun_o,
    output logic                         overrun_o
);

    localparam int unsigned AccW = acc_width(NUM_CH, SAMPLE_W);
    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TmoW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    mix_state_e                 state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [NUM_CH-1:0]          en_q, en_d;
    logic [TmoW-1:0]            tmo_q, tmo_d;
    logic signed [AccW-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [2*SAMPLE_W-1:0]      mix_q, mix_d, sample_q, sample_d;
    logic                       underrun_q, underrun_d, overrun_q, overrun_d;
`ifdef AUD_MIX_ATTEN_EN
    logic [NUM_CH*4-1:0]        atten_q, atten_d;
`endif

    logic signed [SAMPLE_W-1:0] sel_l, sel_r;
    logic signed [AccW-1:0]     add_l, add_r;
    logic [SAMPLE_W-1:0]        sat_l, sat_r;
    logic                       adv, last_ch;

    aud_sat #(.InW(AccW), .OutW(SAMPLE_W)) u_sat_l (.acc_i(acc_l_q), .sat_o(sat_l));
    aud_sat #(.InW(AccW), .OutW(SAMPLE_W)) u_sat_r (.acc_i(acc_r_q), .sat_o(sat_r));

    always_comb begin
        sel_l = ch_left_i[int'(idx_q)*SAMPLE_W +: SAMPLE_W];
        sel_r = ch_right_i[int'(idx_q)*SAMPLE_W +: SAMPLE_W];
`ifdef AUD_MIX_ATTEN_EN
        add_l = AccW'(sel_l) >>> atten_q[int'(idx_q)*4 +: 4];
        add_r = AccW'(sel_r) >>> atten_q[int'(idx_q)*4 +: 4];
`else
        add_l = AccW'(sel_l);
        add_r = AccW'(sel_r);
`endif
    end

    assign last_ch = (idx_q == IdxW'(NUM_CH - 1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        en_d       = en_q;
        tmo_d      = tmo_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        mix_d      = mix_q;
        sample_d   = sample_q;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;
        adv        = 1'b0;
`ifdef AUD_MIX_ATTEN_EN
        atten_d    = atten_q;
`endif

        unique case (state_q)
            StIdle: ;
            StSelect: begin
                if (!en_q[idx_q]) begin
                    adv = 1'b1;
                end else begin
                    tmo_d   = TmoW'(TIMEOUT);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (ch_valid_i[idx_q]) begin
                    acc_l_d = acc_l_q + add_l;
                    acc_r_d = acc_r_q + add_r;
                    adv     = 1'b1;
                end else if (tmo_q <= TmoW'(1)) begin
                    underrun_d = 1'b1;
                    adv        = 1'b1;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            StSat: begin
                mix_d   = {sat_l, sat_r};
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (adv) begin
            if (last_ch) begin
                state_d = StSat;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = StSelect;
            end
        end

        // A request always wins: publish the held mix and restart, aborting any pass.
        if (req_i) begin
            sample_d   = mix_q;
            mix_d      = mix_q;
            acc_l_d    = '0;
            acc_r_d    = '0;
            en_d       = ch_en_i;
            idx_d      = '0;
            state_d    = StSelect;
            underrun_d = 1'b0;
            overrun_d  = (state_q != StIdle);
`ifdef AUD_MIX_ATTEN_EN
            atten_d    = ch_atten_i;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            en_q       <= '0;
            tmo_q      <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            mix_q      <= '0;
            sample_q   <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef AUD_MIX_ATTEN_EN
            atten_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            en_q       <= en_d;
            tmo_q      <= tmo_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            mix_q      <= mix_d;
            sample_q   <= sample_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
`ifdef AUD_MIX_ATTEN_EN
            atten_q    <= atten_d;
`endif
        end
    end

    always_comb begin
        ch_req_o = '0;
        if (state_q == StWait) begin
            ch_req_o[idx_q] = 1'b1;
        end
    end

    assign sample_o   = sample_q;
    assign busy_o     = (state_q != StIdle);
    assign underrun_o = underrun_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_aud_mix_sched.sv
// Directed self-checking bench for aud_mix_sched (NUM_CH=4, SAMPLE_W=16, TIMEOUT=32).
module tb_aud_mix_sched;
    import aud_pkg::*;

    localparam int unsigned NCh = 4;
    localparam int unsigned SW  = 16;
    localparam int unsigned Tmo = 32;

    logic                clk = 1'b0;
    logic                rst_ni = 1'b0;
    logic                req_i = 1'b0;
    logic [2*SW-1:0]     sample_o;
    logic [NCh-1:0]      ch_en_i = '1;
    logic [NCh-1:0]      ch_req_o;
    logic [NCh-1:0]      ch_valid_i;
    logic [NCh*SW-1:0]   ch_left_i, ch_right_i;
    logic                busy_o, underrun_o, overrun_o;
`ifdef AUD_MIX_ATTEN_EN
    logic [NCh*4-1:0]    ch_atten_i = '0;
`endif

    logic signed [SW-1:0] src_l [NCh];
    logic signed [SW-1:0] src_r [NCh];
    logic [NCh-1:0]       src_ok = '1;

    int errors = 0;
    int checks = 0;

    aud_mix_sched #(.NUM_CH(NCh), .SAMPLE_W(SW), .TIMEOUT(Tmo)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .sample_o   (sample_o),
        .ch_en_i    (ch_en_i),
`ifdef AUD_MIX_ATTEN_EN
        .ch_atten_i (ch_atten_i),
`endif
        .ch_req_o   (ch_req_o),
        .ch_valid_i (ch_valid_i),
        .ch_left_i  (ch_left_i),
        .ch_right_i (ch_right_i),
        .busy_o     (busy_o),
        .underrun_o (underrun_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        ch_left_i  = '0;
        ch_right_i = '0;
        for (int i = 0; i < NCh; i++) begin
            ch_left_i[i*SW +: SW]  = src_l[i];
            ch_right_i[i*SW +: SW] = src_r[i];
        end
    end
    assign ch_valid_i = src_ok;

    // Strobe monitor: fetch order, one-hot property, underrun timing.
    logic [NCh-1:0] req_log [$];
    logic [NCh-1:0] prev_req = '0;
    int cyc = 0;
    int rise2_cyc = 0;
    int ur_cyc = 0;
    int ur_cnt = 0;
    int onehot_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ch_req_o != prev_req && ch_req_o != '0) req_log.push_back(ch_req_o);
        if (ch_req_o[2] && !prev_req[2]) rise2_cyc = cyc;
        if (!$onehot0(ch_req_o)) onehot_bad++;
        if (underrun_o) begin
            ur_cnt++;
            ur_cyc = cyc;
        end
        prev_req = ch_req_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_req();
        req_i = 1'b1;
        step();
        req_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 400) begin
            step();
            n++;
        end
        chk(tag, {63'd0, busy_o}, 64'd0);
    endtask

    task automatic set_src(input int i, input logic signed [SW-1:0] l,
                           input logic signed [SW-1:0] r);
        src_l[i] = l;
        src_r[i] = r;
    endtask

    task automatic chk_frame(input string tag, input logic signed [SW-1:0] l,
                             input logic signed [SW-1:0] r);
        aud_frame_t f;
        f.left  = l;
        f.right = r;
        chk(tag, {32'd0, sample_o}, {32'd0, f});
    endtask

    initial begin
        for (int i = 0; i < NCh; i++) set_src(i, 16'sd0, 16'sd0);
        step();
        step();
        // Reset state.
        chk("rst_sample", {32'd0, sample_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_chreq", {60'd0, ch_req_o}, 64'd0);
        chk("rst_underrun", {63'd0, underrun_o}, 64'd0);
        chk("rst_overrun", {63'd0, overrun_o}, 64'd0);
        rst_ni = 1'b1;
        step();

        // Basic four-source sum and fetch order.
        set_src(0, 16'sd100, -16'sd100);
        set_src(1, 16'sd200, -16'sd200);
        set_src(2, 16'sd300, -16'sd300);
        set_src(3, 16'sd400, -16'sd400);
        req_log.delete();
        pulse_req();
        chk_frame("t1_first_publish", 16'sd0, 16'sd0);
        chk("t1_busy", {63'd0, busy_o}, 64'd1);
        wait_idle("t1_done");
        chk("t1_order_len", 64'(req_log.size()), 64'd4);
        for (int i = 0; i < NCh; i++) begin
            if (i < req_log.size()) chk("t1_order", {60'd0, req_log[i]}, 64'(1 << i));
        end
        pulse_req();
        chk_frame("t1_mix", 16'sd1000, -16'sd1000);
        wait_idle("t1_done2");

        // Saturation in both directions.
        for (int i = 0; i < NCh; i++) set_src(i, 16'sh7000, 16'sh9000);
        pulse_req();
        chk_frame("t2_prev", 16'sd1000, -16'sd1000);
        wait_idle("t2_done");
        pulse_req();
        chk_frame("t2_sat", 16'sh7fff, 16'sh8000);
        wait_idle("t2_done2");

        // Disabled sources are skipped without a strobe.
        set_src(0, 16'sd10, -16'sd10);
        set_src(1, 16'sd20, -16'sd20);
        set_src(2, 16'sd30, -16'sd30);
        set_src(3, 16'sd40, -16'sd40);
        ch_en_i = 4'b0101;
        req_log.delete();
        pulse_req();
        wait_idle("t3_done");
        chk("t3_order_len", 64'(req_log.size()), 64'd2);
        if (req_log.size() == 2) begin
            chk("t3_first", {60'd0, req_log[0]}, 64'h1);
            chk("t3_second", {60'd0, req_log[1]}, 64'h4);
        end
        pulse_req();
        chk_frame("t3_mix", 16'sd40, -16'sd40);
        wait_idle("t3_done2");

        // Source 2 silent: one underrun, TIMEOUT cycles after its strobe rises.
        ch_en_i = 4'b1111;
        set_src(0, 16'sd100, -16'sd100);
        set_src(1, 16'sd200, -16'sd200);
        set_src(2, 16'sd300, -16'sd300);
        set_src(3, 16'sd400, -16'sd400);
        src_ok = 4'b1011;
        ur_cnt = 0;
        pulse_req();
        wait_idle("t4_done");
        chk("t4_ur_count", 64'(ur_cnt), 64'd1);
        chk("t4_ur_delay", 64'(ur_cyc - rise2_cyc), 64'(Tmo));
        pulse_req();
        chk_frame("t4_mix", 16'sd700, -16'sd700);
        wait_idle("t4_done2");

        // Request mid-pass aborts, republishes stale mix and restarts at source 0.
        src_ok = 4'b1111;
        pulse_req();
        wait_idle("t5_done");
        pulse_req();
        chk_frame("t5_publish", 16'sd1000, -16'sd1000);
        step();
        step();
        step();
        req_log.delete();
        pulse_req();
        chk("t5_overrun", {63'd0, overrun_o}, 64'd1);
        chk("t5_busy", {63'd0, busy_o}, 64'd1);
        chk_frame("t5_stale", 16'sd1000, -16'sd1000);
        step();
        chk("t5_overrun_pulse", {63'd0, overrun_o}, 64'd0);
        chk("t5_restart", {60'd0, ch_req_o}, 64'h1);
        wait_idle("t5_done2");
        chk("t5_order_len", 64'(req_log.size()), 64'd4);

        // Async reset during WAIT clears everything, including the mix buffer.
        pulse_req();
        begin
            int n = 0;
            while (ch_req_o == '0 && n < 50) begin
                step();
                n++;
            end
        end
        chk("t6_in_wait", {63'd0, |ch_req_o}, 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_sample", {32'd0, sample_o}, 64'd0);
        chk("t6_chreq", {60'd0, ch_req_o}, 64'd0);
        chk("t6_busy", {63'd0, busy_o}, 64'd0);
        chk("t6_flags", {62'd0, underrun_o, overrun_o}, 64'd0);
        step();
        rst_ni = 1'b1;
        step();
        pulse_req();
        chk_frame("t6_after_reset", 16'sd0, 16'sd0);
        wait_idle("t6_done");

        chk("onehot_strobe", 64'(onehot_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
